frame_pattern_gen: RTL and testbench
====================================

# frame_pattern_gen

Parametrised frame pattern source for link and filter testing: emits framed words (head comma, sequence word, payload, tail comma) over a valid/ready stream. Payload length, payload mode and inversion are selectable per frame, and the block honours downstream backpressure. It drives the DUT input path and a matching checker on the receive side. The frame layout is fixed and shared with that checker.

## Interface
Parameters:
- DATA_W, 10, word width
- LEN_W, 11, width of payload length field
- CNT_W, 16, width of frame counter
- POLY_LENGTH, 9, LFSR length
- POLY_TAP, 5, second LFSR tap
- HEAD_WORD, 10'b1100110011, head comma (DATA_W wide)
- TAIL_WORD, 10'b1100110011, tail comma (DATA_W wide)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- send_enable  in  1  request frames; sampled in IDLE and on the TAIL transfer
- payload_len  in  LEN_W  payload words per frame; 0 treated as 1; latched at frame start
- mode  in  1  0 = PRBS payload, 1 = incrementing-count payload; latched at frame start
- invert  in  1  invert payload bits (not head/seq/tail); latched at frame start
- data_ready  in  1  downstream accepts word
- data_out  out  DATA_W  word
- data_valid  out  1  data_out valid
- sof  out  1  high with the HEAD word
- eof  out  1  high with the TAIL word
- frame_cnt  out  CNT_W  completed frames
- busy  out  1  high in any state other than IDLE

## Operation
- A transfer occurs when data_valid && data_ready. All outputs are registered.
- States:
  - IDLE: data_valid=0, data_out=0. When send_enable=1, load length, mode and invert; go to HEAD.
  - HEAD: data_out=HEAD_WORD, sof=1. Reseed the LFSR to all-ones. Clear the payload index. On transfer, go to SEQ.
  - SEQ: data_out=frame_cnt[DATA_W-1:0] (zero-extended if CNT_W<DATA_W). On transfer, go to PAYLOAD.
  - PAYLOAD: data_out=payload word k, XOR all-ones if invert. On each transfer, k increments. After word len-1 transfers, go to TAIL.
  - TAIL: data_out=TAIL_WORD, eof=1. On transfer, frame_cnt+1 (wraps to 0). Then go to HEAD with a new latch if send_enable=1, otherwise to IDLE.
- PRBS payload:
  - Fibonacci LFSR, feedback f = s[POLY_LENGTH-1] ^ s[POLY_TAP-1], shift left inserting f.
  - Each word takes DATA_W successive f bits, first bit generated in the MSB.
  - The LFSR advances only on a payload transfer.
  - Every frame carries the identical payload sequence.
- Count payload: word k = k mod 2^DATA_W.
- While data_valid=1 and data_ready=0, data_out, sof, eof and state hold. No LFSR or index advance.
- Changes to payload_len, mode and invert mid-frame have no effect until the next frame start.
- Deasserting send_enable mid-frame has no effect; the current frame completes.

## Timing
- Reset: data_out=0, data_valid=0, sof=0, eof=0, frame_cnt=0, busy=0, state IDLE. Applies on the first clk edge with rst_n=0, including mid-frame; the partial frame is dropped.
- Latency: send_enable sampled high in IDLE on edge n gives the HEAD word valid after edge n.
- Frame length is payload_len+3 transfers (4 when payload_len=0).
- Back-to-back: with data_ready=1 there are zero idle cycles between TAIL and the next HEAD.
- frame_cnt updates on the edge of the TAIL transfer. The next frame's SEQ word carries the updated value.

## Structure
- Package frame_pattern_pkg: state encoding (IDLE, HEAD, SEQ, PAYLOAD, TAIL), mode constants, default HEAD/TAIL words. Shared with the checker.
- Sub-module prbs_word_gen: parallel LFSR producing a DATA_W-bit word per enable. Inputs load (seed all-ones) and en.

## Test plan
- mode=1, payload_len=4, data_ready=1, one send_enable pulse -> 0x333 (sof), 0x000, 0x000, 0x001, 0x002, 0x003, 0x333 (eof); then IDLE, frame_cnt=1.
- Same as above with data_ready toggling pseudo-randomly -> identical accepted word sequence; data_out stable whenever valid && !ready.
- send_enable held high, payload_len=2, mode=1 -> contiguous frames, SEQ words 0x000, 0x001, 0x002, no gap cycles.
- mode=0, payload_len=16, three frames, invert=1 on the second -> payload matches the software PRBS model. Frames 1 and 3 are identical; frame 2 is the bitwise complement.
- payload_len=0 -> exactly one payload word; rst_n low during PAYLOAD -> next cycle data_valid=0, frame_cnt=0, next frame starts cleanly.
- CNT_W=2, five frames -> SEQ words 0, 1, 2, 3, 0; frame_cnt wraps 3 -> 0.

Source files
------------

// File: rtl/frame_pattern_pkg.sv
// Shared definitions for the frame pattern generator and its receive-side checker:
// state encoding, payload mode constants and the default comma words.
package frame_pattern_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD    = 3'd1,
      ST_SEQ     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_TAIL    = 3'd4
   } state_t;

   localparam logic MODE_PRBS  = 1'b0;
   localparam logic MODE_COUNT = 1'b1;

   localparam logic [9:0] DEFAULT_HEAD_WORD = 10'b1100110011;
   localparam logic [9:0] DEFAULT_TAIL_WORD = 10'b1100110011;

endpackage

// File: rtl/prbs_word_gen.sv
// Parallel Fibonacci LFSR: presents the next DATA_W feedback bits (first bit in the MSB)
// and the word after that, so the caller can register either one.
module prbs_word_gen #(
   parameter int DATA_W      = 10,
   parameter int POLY_LENGTH = 9,
   parameter int POLY_TAP    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              en,
   output logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] word_next
);

   logic [POLY_LENGTH-1:0] lfsr_q;
   logic [POLY_LENGTH-1:0] lfsr_adv;
   logic [POLY_LENGTH-1:0] s;
   logic                   fb;

   // Unroll 2*DATA_W serial shifts: the first DATA_W form the current word and the
   // state the LFSR moves to on en, the next DATA_W form the word after that.
   always_comb begin
      s         = lfsr_q;
      fb        = 1'b0;
      word      = '0;
      word_next = '0;
      lfsr_adv  = '0;
      for (int i = 0; i < DATA_W; i++) begin
         fb                = s[POLY_LENGTH-1] ^ s[POLY_TAP-1];
         word[DATA_W-1-i]  = fb;
         s                 = {s[POLY_LENGTH-2:0], fb};
      end
      lfsr_adv = s;
      for (int i = 0; i < DATA_W; i++) begin
         fb                    = s[POLY_LENGTH-1] ^ s[POLY_TAP-1];
         word_next[DATA_W-1-i] = fb;
         s                     = {s[POLY_LENGTH-2:0], fb};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || load) begin
         lfsr_q <= '1;
      end else if (en) begin
         lfsr_q <= lfsr_adv;
      end
   end

endmodule

// File: rtl/frame_pattern_gen.sv
// Framed test-pattern source: HEAD comma, sequence word, PRBS or count payload, TAIL comma,
// streamed over valid/ready with all outputs registered.
module frame_pattern_gen
   import frame_pattern_pkg::*;
#(
   parameter int                DATA_W      = 10,
   parameter int                LEN_W       = 11,
   parameter int                CNT_W       = 16,
   parameter int                POLY_LENGTH = 9,
   parameter int                POLY_TAP    = 5,
   parameter logic [DATA_W-1:0] HEAD_WORD   = DATA_W'(DEFAULT_HEAD_WORD),
   parameter logic [DATA_W-1:0] TAIL_WORD   = DATA_W'(DEFAULT_TAIL_WORD)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              send_enable,
   input  logic [LEN_W-1:0]  payload_len,
   input  logic              mode,
   input  logic              invert,
   input  logic              data_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              sof,
   output logic              eof,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              busy
);

   state_t            state_q, state_d;
   logic              xfer;
   logic              frame_start;
   logic              last_word;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx_q;
   logic [LEN_W-1:0]  idx_next;
   logic              mode_q;
   logic              invert_q;
   logic [DATA_W-1:0] seq_word;
   logic [DATA_W-1:0] idx_word;
   logic [DATA_W-1:0] prbs_word;
   logic [DATA_W-1:0] prbs_word_next;
   logic [DATA_W-1:0] pay_first;
   logic [DATA_W-1:0] pay_next;
   logic [DATA_W-1:0] data_d;
   logic              sof_d;
   logic              eof_d;

   assign xfer        = data_valid && data_ready;
   assign frame_start = send_enable && ((state_q == ST_IDLE) || (state_q == ST_TAIL && xfer));
   assign last_word   = (idx_q == len_q - LEN_W'(1));
   assign idx_next    = idx_q + LEN_W'(1);

   // The sequence word carries the frame counter and the count payload carries the
   // payload index, each truncated or zero-extended to the word width.
   generate
      if (CNT_W >= DATA_W) begin : g_seq_trunc
         assign seq_word = frame_cnt[DATA_W-1:0];
      end else begin : g_seq_ext
         assign seq_word = {{(DATA_W-CNT_W){1'b0}}, frame_cnt};
      end
      if (LEN_W >= DATA_W) begin : g_idx_trunc
         assign idx_word = idx_next[DATA_W-1:0];
      end else begin : g_idx_ext
         assign idx_word = {{(DATA_W-LEN_W){1'b0}}, idx_next};
      end
   endgenerate

   prbs_word_gen #(
      .DATA_W      (DATA_W),
      .POLY_LENGTH (POLY_LENGTH),
      .POLY_TAP    (POLY_TAP)
   ) u_prbs (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (state_q == ST_HEAD),
      .en        ((state_q == ST_PAYLOAD) && xfer),
      .word      (prbs_word),
      .word_next (prbs_word_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         len_q    <= LEN_W'(1);
         mode_q   <= MODE_PRBS;
         invert_q <= 1'b0;
      end else if (frame_start) begin
         len_q    <= (payload_len == '0) ? LEN_W'(1) : payload_len;
         mode_q   <= mode;
         invert_q <= invert;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q     <= '0;
         frame_cnt <= '0;
      end else begin
         if (state_q == ST_HEAD) begin
            idx_q <= '0;
         end else if (state_q == ST_PAYLOAD && xfer && !last_word) begin
            idx_q <= idx_next;
         end
         if (state_q == ST_TAIL && xfer) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end
   end

   // Payload word 0 is loaded on the SEQ transfer; later words on each payload transfer.
   always_comb begin
      pay_first = '0;
      pay_next  = '0;
      case (mode_q)
         MODE_PRBS: begin
            pay_first = prbs_word;
            pay_next  = prbs_word_next;
         end
         MODE_COUNT: begin
            pay_first = '0;
            pay_next  = idx_word;
         end
      endcase
      pay_first = pay_first ^ {DATA_W{invert_q}};
      pay_next  = pay_next ^ {DATA_W{invert_q}};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (send_enable)       state_d = ST_HEAD;
         ST_HEAD:    if (xfer)              state_d = ST_SEQ;
         ST_SEQ:     if (xfer)              state_d = ST_PAYLOAD;
         ST_PAYLOAD: if (xfer && last_word) state_d = ST_TAIL;
         ST_TAIL:    if (xfer)              state_d = send_enable ? ST_HEAD : ST_IDLE;
         default:                           state_d = ST_IDLE;
      endcase
   end

   // Computes the word the output registers take on this edge; without a transfer
   // everything holds so a stalled word stays stable.
   always_comb begin
      data_d = data_out;
      sof_d  = sof;
      eof_d  = eof;
      case (state_q)
         ST_IDLE: begin
            data_d = send_enable ? HEAD_WORD : '0;
            sof_d  = send_enable;
            eof_d  = 1'b0;
         end
         ST_HEAD: if (xfer) begin
            data_d = seq_word;
            sof_d  = 1'b0;
         end
         ST_SEQ: if (xfer) begin
            data_d = pay_first;
         end
         ST_PAYLOAD: if (xfer) begin
            data_d = last_word ? TAIL_WORD : pay_next;
            eof_d  = last_word;
         end
         ST_TAIL: if (xfer) begin
            data_d = send_enable ? HEAD_WORD : '0;
            sof_d  = send_enable;
            eof_d  = 1'b0;
         end
         default: begin
            data_d = '0;
            sof_d  = 1'b0;
            eof_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         sof        <= 1'b0;
         eof        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_out   <= data_d;
         data_valid <= (state_d != ST_IDLE);
         sof        <= sof_d;
         eof        <= eof_d;
         busy       <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Self-checking bench for frame_pattern_gen: builds expected frames from a serial PRBS /
// count model and compares every accepted word under random backpressure.
module tb_frame_pattern_gen;

   localparam int                DATA_W      = 10;
   localparam int                LEN_W       = 11;
   localparam int                CNT_W       = 2;
   localparam int                POLY_LENGTH = 9;
   localparam int                POLY_TAP    = 5;
   localparam logic [DATA_W-1:0] HEAD_W      = 10'h333;
   localparam logic [DATA_W-1:0] TAIL_W      = 10'h333;
   localparam int                MAX_LEN     = 40;
   localparam int                PRBS_BITS   = DATA_W * MAX_LEN;

   logic              clk;
   logic              rst_n;
   logic              send_enable;
   logic [LEN_W-1:0]  payload_len;
   logic              mode;
   logic              invert;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              sof;
   logic              eof;
   logic [CNT_W-1:0]  frame_cnt;
   logic              busy;

   typedef struct {
      int len;
      bit mode;
      bit inv;
   } frame_t;

   frame_t            pend_q[$];
   logic [DATA_W+1:0] exp_q[$];
   bit                prbs_bits[PRBS_BITS];
   int                checks    = 0;
   int                failures  = 0;
   int                model_cnt = 0;
   int                gaps;

   frame_pattern_gen #(
      .DATA_W      (DATA_W),
      .LEN_W       (LEN_W),
      .CNT_W       (CNT_W),
      .POLY_LENGTH (POLY_LENGTH),
      .POLY_TAP    (POLY_TAP),
      .HEAD_WORD   (HEAD_W),
      .TAIL_WORD   (TAIL_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .send_enable (send_enable),
      .payload_len (payload_len),
      .mode        (mode),
      .invert      (invert),
      .data_ready  (data_ready),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .sof         (sof),
      .eof         (eof),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input bit se, input int len, input bit m, input bit inv);
      send_enable = se;
      payload_len = LEN_W'(len);
      mode        = m;
      invert      = inv;
   endtask

   task automatic apply_garbage();
      apply_stimulus($urandom_range(0, 1) == 1, int'($urandom_range(0, 2047)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
   endtask

   // Bit-serial reference: the feedback stream from an all-ones seed, one bit per shift.
   task automatic prbs_init();
      int s;
      int f;
      s = (1 << POLY_LENGTH) - 1;
      for (int j = 0; j < PRBS_BITS; j++) begin
         f            = ((s >> (POLY_LENGTH - 1)) ^ (s >> (POLY_TAP - 1))) & 1;
         prbs_bits[j] = (f != 0);
         s            = ((s << 1) | f) & ((1 << POLY_LENGTH) - 1);
      end
   endtask

   function automatic logic [DATA_W-1:0] prbs_word(input int k);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = prbs_bits[k*DATA_W + b];
      return w;
   endfunction

   task automatic queue_frame(input int len, input bit m, input bit inv);
      frame_t            fr;
      int                n;
      logic [DATA_W-1:0] w;
      fr.len  = len;
      fr.mode = m;
      fr.inv  = inv;
      pend_q.push_back(fr);
      exp_q.push_back({1'b1, 1'b0, HEAD_W});
      exp_q.push_back({2'b00, DATA_W'(model_cnt)});
      n = (len == 0) ? 1 : len;
      for (int k = 0; k < n; k++) begin
         w = m ? DATA_W'(k % (1 << DATA_W)) : prbs_word(k);
         if (inv) w = ~w;
         exp_q.push_back({2'b00, w});
      end
      exp_q.push_back({1'b0, 1'b1, TAIL_W});
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
   endtask

   // Starts the first queued frame from IDLE, then accepts words until every expected word
   // has been seen; send_enable is raised on a TAIL only while more frames are queued.
   task automatic run_stream(input bit rnd_ready, output int idle_cycles);
      frame_t            fr;
      logic [DATA_W+1:0] obs;
      logic [DATA_W+1:0] held;
      bit                hold;
      bit                rdy;
      int                cyc;
      idle_cycles = 0;
      hold        = 1'b0;
      held        = '0;
      cyc         = 0;
      fr          = pend_q.pop_front();
      apply_stimulus(1'b1, fr.len, fr.mode, fr.inv);
      step();
      while (exp_q.size() > 0 && cyc < 5000) begin
         obs = {sof, eof, data_out};
         if (hold) check_output("hold_stable", 32'(obs), 32'(held));
         if (!data_valid) idle_cycles++;
         rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (data_valid && rdy) begin
            check_output("word", 32'(obs), 32'(exp_q.pop_front()));
            if (eof && pend_q.size() > 0) begin
               fr = pend_q.pop_front();
               apply_stimulus(1'b1, fr.len, fr.mode, fr.inv);
            end else if (eof) begin
               apply_stimulus(1'b0, int'($urandom_range(0, 2047)), 1'b0, 1'b0);
            end else begin
               apply_garbage();
            end
         end else begin
            apply_garbage();
         end
         hold       = data_valid && !rdy;
         held       = obs;
         data_ready = rdy;
         step();
         cyc++;
      end
      check_output("stream_drained", 32'(exp_q.size()), 32'd0);
      apply_stimulus(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic check_idle(input string tag);
      check_output({tag, "_valid"}, 32'(data_valid), 32'd0);
      check_output({tag, "_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_data"}, 32'(data_out), 32'd0);
      check_output({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(model_cnt));
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      data_ready = 1'b0;
      apply_stimulus(1'b0, 0, 1'b0, 1'b0);
      step();
      step();
      rst_n     = 1'b1;
      model_cnt = 0;
      exp_q.delete();
      pend_q.delete();
   endtask

   initial begin
      rst_n      = 1'b0;
      data_ready = 1'b0;
      apply_stimulus(1'b0, 0, 1'b0, 1'b0);
      prbs_init();

      apply_reset();
      check_output("reset_sof", 32'(sof), 32'd0);
      check_output("reset_eof", 32'(eof), 32'd0);
      check_idle("reset");

      $display("[TB] count payload, len 4, ready held high");
      queue_frame(4, 1'b1, 1'b0);
      run_stream(1'b0, gaps);
      check_idle("single_frame");

      $display("[TB] count payload, len 4, random backpressure");
      queue_frame(4, 1'b1, 1'b0);
      run_stream(1'b1, gaps);
      check_idle("backpressure");

      $display("[TB] back-to-back frames, len 2");
      apply_reset();
      for (int i = 0; i < 3; i++) queue_frame(2, 1'b1, 1'b0);
      run_stream(1'b0, gaps);
      check_output("b2b_gap_cycles", 32'(gaps), 32'd0);
      check_idle("b2b");

      $display("[TB] PRBS payload, len 16, middle frame inverted");
      queue_frame(16, 1'b0, 1'b0);
      queue_frame(16, 1'b0, 1'b1);
      queue_frame(16, 1'b0, 1'b0);
      run_stream(1'b1, gaps);
      check_idle("prbs");

      $display("[TB] zero length payloads");
      queue_frame(0, 1'b1, 1'b0);
      queue_frame(0, 1'b0, 1'b1);
      queue_frame(1, 1'b0, 1'b0);
      run_stream(1'b1, gaps);
      check_idle("len0");

      $display("[TB] reset during payload");
      data_ready = 1'b1;
      apply_stimulus(1'b1, 8, 1'b1, 1'b0);
      step();
      check_output("rst_mid_head", 32'({sof, eof, data_out}), 32'({1'b1, 1'b0, HEAD_W}));
      apply_stimulus(1'b0, 0, 1'b0, 1'b0);
      step();
      step();
      step();
      check_output("rst_mid_payload1", 32'({sof, eof, data_out}), 32'h001);
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      model_cnt = 0;
      check_output("rst_mid_sof", 32'(sof), 32'd0);
      check_output("rst_mid_eof", 32'(eof), 32'd0);
      check_idle("rst_mid");
      queue_frame(3, 1'b1, 1'b0);
      run_stream(1'b1, gaps);
      check_idle("after_rst");

      $display("[TB] frame counter wrap");
      apply_reset();
      for (int i = 0; i < 5; i++)
         queue_frame(int'($urandom_range(0, 5)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      run_stream(1'b1, gaps);
      check_idle("wrap");

      $display("[TB] random frames");
      for (int i = 0; i < 8; i++)
         queue_frame(int'($urandom_range(0, MAX_LEN)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      run_stream(1'b1, gaps);
      check_idle("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
